interrupt_controller: RTL and testbench

Memory-mapped interrupt flag (IF, 0xFF0F) and interrupt enable (IE, 0xFFFF) unit.
- Sits directly upstream of the CPU and drives its 5-bit `i_Interrupts` pending vector from peripheral request lines.
- Consumes the CPU's `o_Handle_Interrupt` to acknowledge and clear the serviced flag.
- Returns the service vector address.
- Shares the CPU's OR-combined 8-bit read bus and its address/strobe outputs.

---
 rtl/interrupt_controller.sv | 117 +++++++++++
 tb/tb_interrupt_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Interrupt flag (IF) and enable (IE) registers with edge-captured requests,
// priority acknowledge and a latched service vector.
module interrupt_controller #(
    parameter logic [15:0] IF_ADDR     = 16'hFF0F,
    parameter logic [15:0] IE_ADDR     = 16'hFFFF,
    parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic        i_Enable,
    input  logic [15:0] i_Address,
    input  logic [7:0]  i_Data,
    input  logic        i_Write,
    input  logic        i_Read,
    input  logic [4:0]  i_Requests,
    input  logic        i_Handle_Interrupt,
    output logic [4:0]  o_Interrupts,
    output logic [7:0]  o_Data,
    output logic [15:0] o_Vector,
    output logic        o_Ack_Valid
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t      state_reg;
    logic [4:0]  if_reg;
    logic [7:0]  ie_reg;
    logic [4:0]  req_reg;
    logic [15:0] vector_reg;
    logic        ack_valid_reg;

    logic [4:0]  req_rise;
    logic [4:0]  pending;
    logic        if_write;
    logic        ie_write;
    logic        ack_trigger;
    logic [4:0]  ack_mask;
    logic [2:0]  ack_index;
    logic [15:0] vector_next;
    logic [4:0]  if_next;

    assign req_rise    = i_Requests & ~req_reg;
    assign pending     = if_reg & ie_reg[4:0];
    assign if_write    = i_Write && (i_Address == IF_ADDR);
    assign ie_write    = i_Write && (i_Address == IE_ADDR);
    assign ack_trigger = (state_reg == IDLE) && i_Handle_Interrupt;

    // Lowest set bit has the highest priority (VBlank first).
    always_comb begin
        ack_index = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) begin
                ack_index = 3'(i);
            end
        end
    end

    always_comb begin
        ack_mask = 5'd0;
        if (ack_trigger) begin
            ack_mask = pending & (~pending + 5'd1);
        end
    end

    // An empty pending set yields a zero vector so the CPU can cancel dispatch.
    assign vector_next = (pending == 5'd0) ? 16'h0000
                       : VECTOR_BASE + {10'd0, ack_index, 3'b000};

    assign if_next = ((if_write ? i_Data[4:0] : if_reg) & ~ack_mask) | req_rise;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_reg     <= IDLE;
            if_reg        <= 5'h00;
            ie_reg        <= 8'h00;
            req_reg       <= 5'h00;
            vector_reg    <= 16'h0000;
            ack_valid_reg <= 1'b0;
        end else if (i_Enable) begin
            if_reg  <= if_next;
            req_reg <= i_Requests;
            if (ie_write) begin
                ie_reg <= i_Data;
            end
            case (state_reg)
                IDLE: begin
                    if (i_Handle_Interrupt) begin
                        state_reg     <= ACK;
                        vector_reg    <= vector_next;
                        ack_valid_reg <= 1'b1;
                    end
                end
                ACK: begin
                    if (!i_Handle_Interrupt) begin
                        state_reg     <= IDLE;
                        ack_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_Data = 8'h00;
        if (i_Read && (i_Address == IF_ADDR)) begin
            o_Data = {3'b111, if_reg};
        end else if (i_Read && (i_Address == IE_ADDR)) begin
            o_Data = ie_reg;
        end
    end

    assign o_Interrupts = pending;
    assign o_Vector     = vector_reg;
    assign o_Ack_Valid  = ack_valid_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized and directed bench for interrupt_controller against a
// behavioural model of the flag/enable/acknowledge rules.
module tb_interrupt_controller;

    logic        i_Clk = 1'b0;
    logic        i_Reset_n;
    logic        i_Enable;
    logic [15:0] i_Address;
    logic [7:0]  i_Data;
    logic        i_Write;
    logic        i_Read;
    logic [4:0]  i_Requests;
    logic        i_Handle_Interrupt;
    logic [4:0]  o_Interrupts;
    logic [7:0]  o_Data;
    logic [15:0] o_Vector;
    logic        o_Ack_Valid;

    int checks   = 0;
    int failures = 0;

    interrupt_controller dut (
        .i_Clk              (i_Clk),
        .i_Reset_n          (i_Reset_n),
        .i_Enable           (i_Enable),
        .i_Address          (i_Address),
        .i_Data             (i_Data),
        .i_Write            (i_Write),
        .i_Read             (i_Read),
        .i_Requests         (i_Requests),
        .i_Handle_Interrupt (i_Handle_Interrupt),
        .o_Interrupts       (o_Interrupts),
        .o_Data             (o_Data),
        .o_Vector           (o_Vector),
        .o_Ack_Valid        (o_Ack_Valid)
    );

    always #5 i_Clk = ~i_Clk;

    // Behavioural model state
    logic [4:0]  m_if;
    logic [7:0]  m_ie;
    logic [4:0]  m_prev;
    logic [15:0] m_vec;
    bit          m_in_ack;

    task automatic model_reset();
        m_if = 5'h00; m_ie = 8'h00; m_prev = 5'h00; m_vec = 16'h0000; m_in_ack = 1'b0;
    endtask

    task automatic model_step();
        logic [4:0] rise;
        logic [4:0] pend;
        logic [4:0] nxt;
        bit         found;
        if (!i_Enable) return;
        rise = i_Requests & ~m_prev;
        pend = m_if & m_ie[4:0];
        nxt  = (i_Write && i_Address == 16'hFF0F) ? i_Data[4:0] : m_if;
        if (!m_in_ack && i_Handle_Interrupt) begin
            m_in_ack = 1'b1;
            m_vec    = 16'h0000;
            found    = 1'b0;
            for (int b = 0; b < 5; b++) begin
                if (!found && pend[b]) begin
                    found  = 1'b1;
                    nxt[b] = 1'b0;
                    m_vec  = 16'h0040 + 16'(8 * b);
                end
            end
        end else if (m_in_ack && !i_Handle_Interrupt) begin
            m_in_ack = 1'b0;
        end
        m_if   = nxt | rise;
        if (i_Write && i_Address == 16'hFFFF) m_ie = i_Data;
        m_prev = i_Requests;
    endtask

    function automatic logic [7:0] model_read();
        if (i_Read && i_Address == 16'hFF0F) return {3'b111, m_if};
        if (i_Read && i_Address == 16'hFFFF) return m_ie;
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("interrupts", {11'd0, o_Interrupts}, {11'd0, m_if & m_ie[4:0]});
        chk("vector", o_Vector, m_vec);
        chk("ack_valid", {15'd0, o_Ack_Valid}, {15'd0, m_in_ack});
        chk("read_data", {8'd0, o_Data}, {8'd0, model_read()});
    endtask

    // The single per-cycle compare: advance the model on the edge, then check.
    task automatic tick();
        @(posedge i_Clk);
        if (!i_Reset_n) model_reset();
        else model_step();
        #2;
        compare_all();
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        i_Write = 1'b1; i_Address = addr; i_Data = data;
        tick();
        $display("wr addr=%h data=%h", addr, data);
        i_Write = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [15:0] addr, input logic [7:0] exp);
        i_Read = 1'b1; i_Address = addr;
        #1;
        chk(name, {8'd0, o_Data}, {8'd0, exp});
        $display("rd addr=%h data=%h", addr, o_Data);
        i_Read = 1'b0;
    endtask

    initial begin
        i_Reset_n = 1'b0; i_Enable = 1'b1; i_Address = 16'h0000; i_Data = 8'h00;
        i_Write = 1'b0; i_Read = 1'b0; i_Requests = 5'h00; i_Handle_Interrupt = 1'b0;
        model_reset();
        repeat (3) tick();
        i_Reset_n = 1'b1;

        // Reset state
        rd_check("reset_if", 16'hFF0F, 8'hE0);
        rd_check("reset_ie", 16'hFFFF, 8'h00);
        chk("reset_int", {11'd0, o_Interrupts}, 16'h0000);
        chk("reset_vec", o_Vector, 16'h0000);
        chk("reset_ack", {15'd0, o_Ack_Valid}, 16'h0000);

        // Single-shot capture of a held line
        wr(16'hFFFF, 8'h1F);
        i_Requests = 5'b00100;
        repeat (10) tick();
        rd_check("capture_if", 16'hFF0F, 8'hE4);
        chk("capture_int", {11'd0, o_Interrupts}, 16'h0004);
        wr(16'hFF0F, 8'h00);
        tick();
        rd_check("held_line_no_reset", 16'hFF0F, 8'hE0);
        i_Requests = 5'b00000;
        tick();

        // Priority acknowledge
        wr(16'hFF0F, 8'h16);
        i_Handle_Interrupt = 1'b1;
        repeat (3) tick();
        chk("ack1_vec", o_Vector, 16'h0048);
        chk("ack1_valid", {15'd0, o_Ack_Valid}, 16'h0001);
        rd_check("ack1_if", 16'hFF0F, 8'hF4);
        i_Handle_Interrupt = 1'b0;
        tick();
        chk("ack1_drop", {15'd0, o_Ack_Valid}, 16'h0000);
        chk("ack1_hold_vec", o_Vector, 16'h0048);
        i_Handle_Interrupt = 1'b1;
        tick();
        chk("ack2_vec", o_Vector, 16'h0050);
        i_Handle_Interrupt = 1'b0;
        tick();

        // Masked and cancelled dispatch
        wr(16'hFFFF, 8'h01);
        wr(16'hFF0F, 8'h02);
        chk("masked_int", {11'd0, o_Interrupts}, 16'h0000);
        i_Handle_Interrupt = 1'b1;
        tick();
        chk("cancel_vec", o_Vector, 16'h0000);
        rd_check("cancel_if", 16'hFF0F, 8'hE2);
        i_Handle_Interrupt = 1'b0;
        tick();

        // Collisions
        i_Requests = 5'b10000;
        wr(16'hFF0F, 8'h00);
        rd_check("write_vs_req", 16'hFF0F, 8'hF0);
        i_Requests = 5'b00000;
        wr(16'hFFFF, 8'h1F);
        wr(16'hFF0F, 8'h01);
        i_Requests = 5'b00001; i_Handle_Interrupt = 1'b1;
        tick();
        rd_check("ack_vs_req", 16'hFF0F, 8'hE1);
        chk("ack_vs_req_vec", o_Vector, 16'h0040);
        i_Requests = 5'b00000; i_Handle_Interrupt = 1'b0;
        tick();

        // Clock enable freezes everything
        i_Enable = 1'b0; i_Requests = 5'b01000;
        wr(16'hFFFF, 8'h00);
        i_Requests = 5'b00000;
        tick();
        i_Enable = 1'b1;
        rd_check("frozen_ie", 16'hFFFF, 8'h1F);
        rd_check("frozen_if", 16'hFF0F, 8'hE1);

        // Reset during ACK
        wr(16'hFFFF, 8'hFF);
        i_Handle_Interrupt = 1'b1;
        tick();
        chk("pre_reset_ack", {15'd0, o_Ack_Valid}, 16'h0001);
        i_Reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_int", {11'd0, o_Interrupts}, 16'h0000);
        chk("rst_vec", o_Vector, 16'h0000);
        chk("rst_ack", {15'd0, o_Ack_Valid}, 16'h0000);
        rd_check("rst_ie", 16'hFFFF, 8'h00);
        i_Handle_Interrupt = 1'b0;
        tick();
        i_Reset_n = 1'b1;

        // Randomized phase against the model
        for (int n = 0; n < 800; n++) begin
            int sel;
            i_Enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) i_Requests = i_Requests ^ (5'b00001 << $urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) i_Handle_Interrupt = ~i_Handle_Interrupt;
            sel = $urandom_range(0, 4);
            i_Address = (sel < 2) ? 16'hFF0F : (sel < 4) ? 16'hFFFF : 16'($urandom);
            i_Data  = 8'($urandom);
            i_Write = ($urandom_range(0, 4) == 0);
            i_Read  = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
